imm_rot_encoder: RTL and testbench



---
 rtl/imm_rot_encoder_if.sv | 13 +
 rtl/imm_rot_encoder.sv | 82 ++++++++
 tb/tb_imm_rot_encoder.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/imm_rot_encoder_if.sv
// Request/result bundle for the rotated-immediate encoder.
// The requester drives start/value; the encoder returns busy/done/found/imm12.
interface imm_rot_encoder_if;
    logic        start;
    logic [31:0] value;
    logic        busy;
    logic        done;
    logic        found;
    logic [11:0] imm12;

    modport master (output start, output value, input busy, input done, input found, input imm12);
    modport slave  (input start, input value, output busy, output done, output found, output imm12);
endinterface

// File: rtl/imm_rot_encoder.sv
// Iterative search for the smallest rot such that value == ror({24'b0, imm8}, rot).
// One rotation is tested per cycle; unencodable values report found=0 after MAX_ROT+1 tests.
module imm_rot_encoder #(
    parameter int MAX_ROT = 15
) (
    input  logic               clk,
    input  logic               reset,
    imm_rot_encoder_if.slave   bus
);
    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_SEARCH = 1'b1;
    localparam logic [3:0] ROT_LAST = 4'(MAX_ROT);

    logic [0:0]  state_q, state_d;
    logic [31:0] cand_q, cand_d;
    logic [3:0]  rot_q, rot_d;
    logic        found_q, found_d;
    logic [11:0] imm12_q, imm12_d;
    logic        done_q, done_d;
    logic        match;

    // cand holds value rotated left by rot, so a match means the low byte is imm8
    assign match = (cand_q[31:8] == 24'd0);

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        rot_d   = rot_q;
        found_d = found_q;
        imm12_d = imm12_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    cand_d  = bus.value;
                    rot_d   = 4'd0;
                    state_d = S_SEARCH;
                end
            end
            S_SEARCH: begin
                if (match) begin
                    found_d = 1'b1;
                    imm12_d = {rot_q, cand_q[7:0]};
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (rot_q == ROT_LAST) begin
                    found_d = 1'b0;
                    imm12_d = 12'd0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cand_d = {cand_q[30:0], cand_q[31]};
                    rot_d  = rot_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cand_q  <= 32'd0;
            rot_q   <= 4'd0;
            found_q <= 1'b0;
            imm12_q <= 12'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            rot_q   <= rot_d;
            found_q <= found_d;
            imm12_q <= imm12_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy  = (state_q == S_SEARCH);
    assign bus.done  = done_q;
    assign bus.found = found_q;
    assign bus.imm12 = imm12_q;
endmodule

// File: tb/tb_imm_rot_encoder.sv
// Scoreboard bench for imm_rot_encoder: expected results are queued at request time
// and compared, with latency and busy length, when done pulses.
module tb_imm_rot_encoder;
    localparam int MAX_ROT = 15;

    typedef struct {
        logic [31:0] value;
        logic        found;
        logic [11:0] imm12;
        int          done_cyc;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   busy_run = 0;
    logic prev_done = 1'b0;
    exp_t sb_q[$];

    imm_rot_encoder_if bus();

    imm_rot_encoder #(.MAX_ROT(MAX_ROT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: try each rotation, rebuild the operand by rotating imm8 right, compare to value.
    task automatic model(input logic [31:0] v, output logic fnd, output logic [11:0] imm, output int lat);
        logic [31:0] rl, op;
        logic [7:0]  imm8;
        fnd = 1'b0;
        imm = 12'd0;
        lat = MAX_ROT + 1;
        for (int r = MAX_ROT; r >= 0; r--) begin
            rl   = (v << r) | (v >> (32 - r));
            imm8 = rl[7:0];
            op   = ({24'd0, imm8} >> r) | ({24'd0, imm8} << (32 - r));
            if (op == v) begin
                fnd = 1'b1;
                imm = {4'(r), imm8};
                lat = r + 1;
            end
        end
    endtask

    // Called at negedge+2; start is sampled at the following posedge.
    task automatic kick(input logic [31:0] v, input bit push);
        exp_t e;
        bus.start = 1'b1;
        bus.value = v;
        if (push) begin
            e.value = v;
            model(v, e.found, e.imm12, e.lat);
            e.done_cyc = cyc + 1 + e.lat;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.value = 32'hDEAD_BEEF;
    endtask

    task automatic wait_empty();
        int n = 0;
        while (sb_q.size() != 0 && n < 40) begin
            @(negedge clk);
            #2;
            n++;
        end
        check("done_timeout", 32'(sb_q.size()), 32'd0);
        if (sb_q.size() != 0) sb_q.delete();
    endtask

    // Output monitor: sampled on the falling edge, away from the active edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (prev_done) check("done_width", bus.done, 1'b0);
                if (bus.done) begin
                    check("busy_with_done", bus.busy, 1'b0);
                    if (sb_q.size() == 0) begin
                        check("unexpected_done", bus.done, 1'b0);
                    end else begin
                        e = sb_q.pop_front();
                        $display("txn value=0x%08h found=%0d imm12=0x%03h latency=%0d busy=%0d",
                                 e.value, bus.found, bus.imm12, cyc - (e.done_cyc - e.lat), busy_run);
                        check("found", bus.found, e.found);
                        check("imm12", bus.imm12, e.imm12);
                        check("latency", cyc, e.done_cyc);
                        check("busy_cycles", busy_run, e.lat);
                    end
                end
                busy_run  = bus.busy ? busy_run + 1 : 0;
                prev_done = bus.done;
            end else begin
                busy_run  = 0;
                prev_done = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] vals [7];
        vals = '{32'h0000_00FF, 32'h0000_0000, 32'h8000_0001, 32'hFF00_0000,
                 32'h0000_0100, 32'hF000_000F, 32'h0002_0000};
        bus.start = 1'b0;
        bus.value = 32'd0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_busy",  bus.busy,  1'b0);
        check("rst_done",  bus.done,  1'b0);
        check("rst_found", bus.found, 1'b0);
        check("rst_imm12", bus.imm12, 12'd0);
        #2 reset = 1'b0;

        // Table of values: zero rotation, zero, rot 1, rot 8, unencodable, rot 4, rot 15
        foreach (vals[i]) begin
            @(negedge clk);
            #2;
            kick(vals[i], 1'b1);
            wait_empty();
        end

        // Results hold after done until the next done, and do not clear on start
        @(negedge clk);
        check("hold_found", bus.found, 1'b1);
        check("hold_imm12", bus.imm12, 12'hF01);

        // Reset mid-search: a found result is present beforehand
        #2 kick(32'hFF00_0000, 1'b0);
        repeat (4) @(negedge clk);
        check("search_busy", bus.busy, 1'b1);
        check("prev_found", bus.found, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("abort_busy",  bus.busy,  1'b0);
        check("abort_done",  bus.done,  1'b0);
        check("abort_found", bus.found, 1'b0);
        check("abort_imm12", bus.imm12, 12'd0);
        @(negedge clk);
        #2 reset = 1'b0;
        repeat (20) @(negedge clk);
        check("post_abort_found", bus.found, 1'b0);
        check("post_abort_busy",  bus.busy,  1'b0);

        // Start while busy is ignored, then back-to-back start in the done cycle
        #2 kick(32'hFF00_0000, 1'b1);
        repeat (3) @(negedge clk);
        #2 kick(32'h0000_00FF, 1'b0);
        wait_empty();
        check("b2b_in_done_cycle", bus.done, 1'b1);
        kick(32'h8000_0001, 1'b1);
        wait_empty();

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
